// File: rtl/data_memory_param.sv
// Byte-enabled single-port data memory with a power-up clear sequence.
// Build option: define DMEM_BYPASS_EN for write-first same-address reads (read-first otherwise).
module data_memory_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic [DATA_W-1:0]   i_mem_write_data,
  input  logic [DATA_W/8-1:0] i_byte_en,
  input  logic                i_mem_write,
  input  logic                i_mem_read,
  output logic [DATA_W-1:0]   o_mem_read_data,
  output logic                o_read_valid,
  output logic                o_busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nx;
  logic                busy_nx;
  logic                read_valid_nx;
  logic [DATA_W-1:0]   read_data_nx;

  logic                we;
  logic                mem_we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [NB-1:0]       wmask;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   stored;
  logic [DATA_W-1:0]   merged;

  // Stored word at the request address and its byte-merged successor.
  always_comb begin
    stored = mem[i_address];
    merged = stored;
    for (int unsigned k = 0; k < NB; k++) begin
      if (i_byte_en[k]) begin
        merged[8*k +: 8] = i_mem_write_data[8*k +: 8];
      end
    end
  end

  // Next-state, write-port steering and output next values.
  always_comb begin
    state_nx      = state;
    clr_cnt_nx    = clr_cnt;
    we            = 1'b0;
    waddr         = i_address;
    wdata         = i_mem_write_data;
    wmask         = i_byte_en;
    read_valid_nx = 1'b0;
    read_data_nx  = o_mem_read_data;

    case (state)
      CLEAR: begin
        we         = 1'b1;
        waddr      = clr_cnt;
        wdata      = '0;
        wmask      = '1;
        clr_cnt_nx = clr_cnt + ADDR_W'(1);
        if (clr_cnt == CLR_LAST) begin
          state_nx = READY;
        end
      end
      READY: begin
        we = i_mem_write;
        if (i_mem_read) begin
          read_valid_nx = 1'b1;
`ifdef DMEM_BYPASS_EN
          read_data_nx  = i_mem_write ? merged : stored;
`else
          read_data_nx  = stored;
`endif
        end
      end
      default: begin
        state_nx = CLEAR;
      end
    endcase

    busy_nx = (state_nx == CLEAR);
  end

  // Reset blocks every memory write, including the clear sequence.
  assign mem_we = we && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= CLEAR;
      clr_cnt         <= '0;
      o_busy          <= 1'b1;
      o_read_valid    <= 1'b0;
      o_mem_read_data <= '0;
    end else begin
      state           <= state_nx;
      clr_cnt         <= clr_cnt_nx;
      o_busy          <= busy_nx;
      o_read_valid    <= read_valid_nx;
      o_mem_read_data <= read_data_nx;
    end
  end

  // Storage array: no reset, zeroed only by the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wmask[k]) begin
          mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_param.sv
// Scoreboard bench for data_memory_param: clear sequence, byte writes, collisions, resets.
`timescale 1ns/1ps
module tb_data_memory_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  i_address;
  logic [31:0] i_mem_write_data;
  logic [3:0]  i_byte_en;
  logic        i_mem_write;
  logic        i_mem_read;
  logic [31:0] o_mem_read_data;
  logic        o_read_valid;
  logic        o_busy;

  data_memory_param #(.DATA_W(32), .ADDR_W(10)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_address        (i_address),
    .i_mem_write_data (i_mem_write_data),
    .i_byte_en        (i_byte_en),
    .i_mem_write      (i_mem_write),
    .i_mem_read       (i_mem_read),
    .o_mem_read_data  (o_mem_read_data),
    .o_read_valid     (o_read_valid),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [1024];
  logic [31:0] last_data;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: either a scheduled read result arrives, or valid is low and data holds.
  always @(negedge clk) begin
    if (mon_on) begin
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("read_valid", 32'(o_read_valid), 32'd1);
        chk("read_data", o_mem_read_data, sbq[0].d);
        last_data = sbq[0].d;
        void'(sbq.pop_front());
      end else begin
        chk("valid_idle", 32'(o_read_valid), 32'd0);
        chk("data_hold", o_mem_read_data, last_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    tick();
  endtask

  // One cycle of stimulus; a read pushes the model value, or lit when has_lit is set.
  task automatic op(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d,
                    input logic [3:0] be, input bit has_lit, input logic [31:0] lit);
    logic [31:0] old, nw, e;
    i_mem_read       = rd;
    i_mem_write      = wr;
    i_address        = a;
    i_mem_write_data = d;
    i_byte_en        = be;
    old = model[a];
    nw  = wr ? merge(old, d, be) : old;
`ifdef DMEM_BYPASS_EN
    e = nw;
`else
    e = old;
`endif
    if (has_lit) e = lit;
    if (rd) sbq.push_back('{d: e, due: cyc + 1});
    model[a] = nw;
    tick();
  endtask

  // Counts cycles with o_busy high; requests are dropped once the clear ends.
  task automatic wait_clear(output int n);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (!o_busy) break;
      n++;
      chk("busy_no_valid", 32'(o_read_valid), 32'd0);
    end
    i_mem_read  = 1'b0;
    i_mem_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 1024; i++) model[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9:0] pool [6];
    pool = '{10'd0, 10'd5, 10'd7, 10'd9, 10'd512, 10'd1023};
    reset = 1'b1; i_address = '0; i_mem_write_data = '0; i_byte_en = '0;
    i_mem_write = 1'b0; i_mem_read = 1'b0;
    last_data = '0;
    tick();

    // Reset state
    chk("rst_busy", 32'(o_busy), 32'd1);
    chk("rst_valid", 32'(o_read_valid), 32'd0);
    chk("rst_data", o_mem_read_data, 32'd0);
    mon_on = 1'b1;

    // Clear with requests hammering address 3 the whole time
    reset = 1'b0;
    i_mem_write = 1'b1; i_mem_read = 1'b1; i_address = 10'd3;
    i_mem_write_data = 32'hDEADBEEF; i_byte_en = 4'hF;
    wait_clear(n);
    chk("busy_cycles", 32'(n), 32'd1024);
    zero_model();

    op(1, 0, 10'd1023, '0, '0, 1, 32'h0);
    op(1, 0, 10'd3, '0, '0, 1, 32'h0);
    idle();

    // Byte lanes
    op(0, 1, 10'd5, 32'hAABBCCDD, 4'b1111, 0, '0);
    op(0, 1, 10'd5, 32'h11223344, 4'b0101, 0, '0);
    op(1, 0, 10'd5, '0, '0, 1, 32'hAA22CC44);
    op(0, 1, 10'd5, 32'h99999999, 4'b0000, 0, '0);
    op(1, 0, 10'd5, '0, '0, 1, 32'hAA22CC44);
    idle();

    // Same-address collision
    op(0, 1, 10'd7, 32'h12345678, 4'hF, 0, '0);
`ifdef DMEM_BYPASS_EN
    op(1, 1, 10'd7, 32'hFFFFFFFF, 4'b0011, 1, 32'h1234FFFF);
`else
    op(1, 1, 10'd7, 32'hFFFFFFFF, 4'b0011, 1, 32'h12345678);
`endif
    op(1, 0, 10'd7, '0, '0, 1, 32'h1234FFFF);
    idle();

    // Random traffic over a small address pool, back-to-back where it lands
    for (int i = 0; i < 200; i++) begin
      op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pool[$urandom_range(0, 5)],
         $urandom, 4'($urandom_range(0, 15)), 0, '0);
    end
    idle();

    // Reset arrives on the edge that would complete a read
    op(0, 1, 10'd9, 32'hCAFEF00D, 4'hF, 0, '0);
    op(1, 0, 10'd9, '0, '0, 1, 32'hCAFEF00D);
    i_mem_read = 1'b1; i_mem_write = 1'b0; i_address = 10'd9; reset = 1'b1;
    tick();
    reset = 1'b0; i_mem_read = 1'b0;
    last_data = '0;
    chk("rst_read_valid", 32'(o_read_valid), 32'd0);
    chk("rst_read_data", o_mem_read_data, 32'd0);

    // Reset again when clr_cnt reaches 500
    repeat (500) tick();
    chk("mid_clear_busy", 32'(o_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_clear(n);
    chk("busy_after_restart", 32'(n), 32'd1024);
    zero_model();

    op(1, 0, 10'd9, '0, '0, 1, 32'h0);
    op(1, 0, 10'd5, '0, '0, 1, 32'h0);
    op(1, 0, 10'd7, '0, '0, 1, 32'h0);
    idle();
    idle();
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_param.md
DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10: word-address width; depth DEPTH = 2^ADDR_W words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_address  input  ADDR_W  word address for read and write.
REQ-006 SHALL have port i_mem_write_data  input  DATA_W  write data.
REQ-007 SHALL have port i_byte_en  input  DATA_W/8  per-byte write strobe; bit k covers bits [8k+7:8k].
REQ-008 SHALL have port i_mem_write  input  1  write request.
REQ-009 SHALL have port i_mem_read  input  1  read request.
REQ-010 SHALL have port o_mem_read_data  output  DATA_W  registered read data.
REQ-011 SHALL have port o_read_valid  output  1  one-cycle pulse: o_mem_read_data holds a newly accepted read.
REQ-012 SHALL have port o_busy  output  1  high while the clear sequence runs; requests ignored.

Function
REQ-013 SHALL implement a two-state FSM, CLEAR and READY; CLEAR is entered on reset.
REQ-014 In CLEAR, SHALL write zero to word clr_cnt each cycle, clr_cnt counting 0..DEPTH-1; on the cycle clr_cnt = DEPTH-1 is written, the next state SHALL be READY.
REQ-015 o_busy SHALL be 1 exactly in CLEAR: DEPTH cycles after reset deasserts.
REQ-016 In CLEAR, i_mem_read and i_mem_write SHALL be ignored: no memory update, o_read_valid = 0.
REQ-017 In READY, a write with i_mem_write = 1 SHALL update only the byte lanes whose i_byte_en bit is 1; i_byte_en = 0 SHALL leave the word unchanged.
REQ-018 In READY, a read with i_mem_read = 1 at edge N SHALL drive the word onto o_mem_read_data and pulse o_read_valid = 1 after edge N+1 (1-cycle latency).
REQ-019 o_mem_read_data SHALL hold its last value until the next accepted read; o_read_valid SHALL be 0 in any cycle without a newly accepted read.
REQ-020 Back-to-back reads on consecutive cycles SHALL each return data with one-cycle latency, giving full throughput.
REQ-021 Read and write on different addresses in the same cycle SHALL proceed independently.
REQ-022 Read and write to the same address in the same cycle SHALL follow REQ-033/REQ-034.
REQ-023 The address SHALL be used unmodified; all 2^ADDR_W values are valid, so there is no wrap or out-of-range case.

Reset
REQ-024 reset = 1 at a rising edge SHALL set state = CLEAR, clr_cnt = 0, o_busy = 1, o_read_valid = 0 and o_mem_read_data = 0.
REQ-025 Reset asserted mid-clear SHALL restart clearing from word 0.
REQ-026 Reset asserted in READY SHALL discard any in-flight read, with no o_read_valid pulse.
REQ-027 Memory SHALL be zeroed only by the clear sequence, not by reset itself.
REQ-028 While reset = 1, no memory write SHALL occur.

Configuration
REQ-029 Macro DMEM_BYPASS_EN SHALL select the same-address read/write behaviour.
REQ-030 With DMEM_BYPASS_EN defined, a same-cycle same-address read SHALL return write-first data: enabled lanes from i_mem_write_data, other lanes the stored bytes.
REQ-031 Without DMEM_BYPASS_EN, the same read SHALL return read-first data: the pre-write stored word.
REQ-032 Under both settings, the memory SHALL hold the merged new word after the edge.
REQ-033 Same-address behaviour with DMEM_BYPASS_EN defined SHALL be as in REQ-030.
REQ-034 Same-address behaviour without DMEM_BYPASS_EN SHALL be as in REQ-031.

Verification
REQ-035 Clear: pulse reset for 1 cycle -> o_busy = 1 for exactly 1024 cycles; afterwards a read of address 1023 returns 0 with o_read_valid = 1 one cycle later.
REQ-036 Byte write: write 0xAABBCCDD to address 5 with i_byte_en = 4'b1111, then 0x11223344 with i_byte_en = 4'b0101 -> read of address 5 returns 0xAA22CC44.
REQ-037 Collision: word 7 holds 0x12345678; same cycle, read 7 and write 0xFFFFFFFF with i_byte_en = 4'b0011 -> 0x1234FFFF with DMEM_BYPASS_EN, 0x12345678 without; a later read returns 0x1234FFFF.
REQ-038 Busy ignore: write 0xDEADBEEF to address 3 while o_busy = 1 -> after the clear, a read of address 3 returns 0 and o_read_valid stayed 0 during the clear.
REQ-039 Reset mid-clear: assert reset at clr_cnt = 500 -> o_busy stays 1 for 1024 further cycles.
REQ-040 Reset mid-read: issue a read, then reset on the next edge -> o_read_valid = 0 and o_mem_read_data = 0.
